// File: rtl/fir_mac_serial.sv
// fir_mac_serial: signed direct-form FIR using one time-shared multiplier.
// A sample is accepted in IDLE, TAPS multiply-accumulate cycles follow in MAC,
// and the saturated result is held in OUT until the consumer takes it.
// Coefficients are written through an independent port at any time.
module fir_mac_serial #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 6,
    parameter int OUT_W  = 8,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] sample,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  result,
    input  logic                     coef_we,
    input  logic [4:0]               coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata
);

    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS);
    localparam int KW     = $clog2(TAPS);

    localparam logic [KW-1:0] K_LAST = KW'(TAPS - 1);
    localparam logic [5:0]    TAPS_L = 6'(TAPS);

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [KW-1:0]            k;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic signed [OUT_W-1:0]  sat_val;
    logic                     last_tap;
    logic                     accept;
    logic                     hand_off;
    logic                     coef_addr_ok;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus handshake strobes for the datapath.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        accept     = 1'b0;
        hand_off   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    hand_off   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Single MAC: current tap product, running sum, shift and clamp.
    always_comb begin
        prod     = x[k] * c[k];
        sum      = acc + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
        shifted  = sum >>> SHIFT;
        last_tap = (k == K_LAST);
        if (shifted > SAT_MAX) begin
            sat_val = SAT_MAX[OUT_W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_val = SAT_MIN[OUT_W-1:0];
        end else begin
            sat_val = shifted[OUT_W-1:0];
        end
    end

    // Delay line, accumulator, tap counter and registered result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                x[i] <= '0;
            end
            acc       <= '0;
            k         <= '0;
            result    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                x[0] <= sample;
                for (int unsigned i = 1; i < TAPS; i++) begin
                    x[i] <= x[i-1];
                end
                acc <= '0;
                k   <= '0;
            end else if (state == MAC) begin
                acc <= sum;
                k   <= k + 1'b1;
                if (last_tap) begin
                    result    <= sat_val;
                    out_valid <= 1'b1;
                end
            end else if (hand_off) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign coef_addr_ok = ({1'b0, coef_addr} < TAPS_L);

    // Coefficient bank; out-of-range addresses are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                c[i] <= '0;
            end
        end else if (coef_we && coef_addr_ok) begin
            c[coef_addr[KW-1:0]] <= coef_wdata;
        end
    end

endmodule
